spi_shift_reg: RTL
==================

Name: spi_shift_reg

Overview:
- Parametrised full-duplex serial shift register; next generation of the 8-bit load/shift transmitter used in the SPI datapath.
- Adds configurable word width, per-transfer bit length, latched MSB/LSB-first order and serial receive.
- Adds a bit counter with busy/done status and a right-aligned receive word.
- Sits between the APB register file (parallel side) and the SPI clock generator, which supplies sh_en_i strobes.

Parameters:
- DW, 8, shift register / maximum transfer width in bits (2..32).
- LW, $clog2(DW+1), width of len_i (derived; do not override).

Ports:
- clk_i  input  1  system clock, all logic on rising edge.
- rst_i  input  1  asynchronous, active-high reset.
- data_i  input  DW  parallel transmit word, right-aligned; bits [len-1:0] are sent.
- ld_i  input  1  load strobe; starts a transfer.
- len_i  input  LW  transfer length in bits; 0 or values above DW are treated as DW.
- lsb_first_i  input  1  bit order, sampled at load: 1 = LSB first, 0 = MSB first.
- sh_en_i  input  1  one-cycle shift strobe, one bit per strobe.
- sdi_i  input  1  serial receive data, sampled on shift cycles.
- sdo_o  output  1  serial transmit data.
- busy_o  output  1  transfer in progress.
- done_o  output  1  one-cycle pulse when the transfer completes.
- data_o  output  DW  received word, right-aligned, updated at completion.

Behaviour:
- Reset (async, any time, including mid-transfer):
  - shreg, bit counter, latched len/order, busy_o, done_o, data_o and sdo_o are all forced to 0.
  - State goes to IDLE.
  - A partial receive word is discarded.
- States:
  - IDLE: busy_o=0; sdo_o=0; sh_en_i ignored.
  - IDLE -> SHIFT on ld_i=1. On that edge:
    - cnt <= N (effective length).
    - ord <= lsb_first_i.
    - MSB-first: shreg <= data_i << (DW-N), so bit N-1 sits at shreg[DW-1].
    - LSB-first: shreg <= data_i.
    - busy_o <= 1.
  - SHIFT: busy_o=1. sdo_o = shreg[DW-1] (MSB-first) or shreg[0] (LSB-first), combinational from shreg. The first bit is valid the cycle after ld_i.
    - Each cycle with sh_en_i=1:
      - MSB-first: shreg <= {shreg[DW-2:0], sdi_i}.
      - LSB-first: shreg <= {sdi_i, shreg[DW-1:1]}.
      - cnt <= cnt-1.
    - On the shift where cnt==1, on that same edge:
      - go to IDLE, busy_o <= 0, done_o <= 1 for exactly one cycle.
      - data_o <= received bits, right-aligned, upper DW-N bits zero.
      - MSB-first: data_o = new shreg[N-1:0]; the first bit received is data_o[N-1].
      - LSB-first: data_o = new shreg >> (DW-N); the first bit received is data_o[0].
- Latency: ld_i to done_o = N shift strobes; done_o asserts on the edge of the Nth strobe. With back-to-back strobes this is N cycles after the ld cycle.
- ld_i while busy_o=1 is ignored: no reload, transfer continues.
- ld_i and sh_en_i in the same IDLE cycle: load wins, no shift. The strobe is not counted.
- ld_i in the cycle done_o is high (IDLE) is accepted. Back-to-back transfers are legal.
- sh_en_i with cnt==0 cannot occur in SHIFT; no wrap-around of cnt.
- data_o holds its value until the next completion or reset.
- len_i and lsb_first_i changes during SHIFT have no effect.

Test Plan:
- Reset: rst_i pulse at t=2ns, clock idle -> all outputs 0 immediately, without a clock edge.
- MSB-first full word: DW=8, data_i=8'hA5, len_i=0, lsb_first_i=0, sdi_i driven 1,0,0,1,1,1,0,0, sh_en_i every 5th cycle -> sdo_o sequence 1,0,1,0,0,1,0,1; done_o one pulse on the 8th strobe; data_o=8'h9C; busy_o low afterwards.
- LSB-first short word: data_i=8'h0B, len_i=4, lsb_first_i=1, sdi_i 1,1,0,1 -> sdo_o 1,1,0,1; done_o after the 4th strobe; data_o=8'h0B.
- Collisions:
  - ld_i=1 with sh_en_i=1 in IDLE -> loaded, cnt unchanged.
  - ld_i=8'hFF mid-transfer -> ignored, original bits continue.
- Back-to-back: ld_i asserted in the done_o cycle with data_i=8'h3C -> new transfer starts; busy_o high the following cycle.
- Reset mid-transfer after 3 strobes -> busy_o=0, data_o keeps 0. Next ld_i with 8'h81 transfers cleanly: sdo_o 1,0,0,0,0,0,0,1.

Source files
------------

// File: rtl/spi_shift_reg.sv
// spi_shift_reg: parametrised full-duplex shift register for the SPI datapath.
// The parallel side loads a right-aligned transmit word. The SPI clock
// generator supplies one sh_en_i strobe per bit. The received bits come out
// right-aligned on data_o when the transfer completes.
//
// state | meaning
// IDLE  | no transfer; sdo_o low, shift strobes ignored, waiting for ld_i
// SHIFT | transfer running; one bit out/in per sh_en_i until cnt reaches 1
module spi_shift_reg #(
  parameter int DW = 8,
  parameter int LW = $clog2(DW + 1)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic [DW-1:0] data_i,
  input  logic          ld_i,
  input  logic [LW-1:0] len_i,
  input  logic          lsb_first_i,
  input  logic          sh_en_i,
  input  logic          sdi_i,
  output logic          sdo_o,
  output logic          busy_o,
  output logic          done_o,
  output logic [DW-1:0] data_o
);

  localparam logic [LW-1:0] DW_L = LW'(DW);
  localparam logic [LW-1:0] ONE_L = LW'(1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t        state;
  state_t        state_nxt;

  logic [DW-1:0] shreg;
  logic [LW-1:0] cnt;
  logic [LW-1:0] len_q;
  logic          ord;

  logic [LW-1:0] len_eff;
  logic [LW-1:0] pad_eff;
  logic [LW-1:0] pad_q;
  logic [DW-1:0] shreg_ld;
  logic [DW-1:0] shreg_sh;
  logic [DW-1:0] rx_word;
  logic          load;
  logic          shift;
  logic          last;

  // Effective length and alignment amounts for the load and the completion.
  // Zero and out-of-range lengths mean a full-width transfer.
  always_comb begin
    len_eff = ((len_i == '0) || (len_i > DW_L)) ? DW_L : len_i;
    pad_eff = DW_L - len_eff;
    pad_q   = DW_L - len_q;
  end

  // Load image, shift image and right-aligned receive word.
  // MSB-first: the word is pre-shifted so bit N-1 leaves first from the top.
  // LSB-first: bits leave from bit 0 and received bits enter at the top,
  // so the received word is the top N bits moved down.
  always_comb begin
    shreg_ld = lsb_first_i ? data_i : (data_i << pad_eff);
    shreg_sh = ord ? {sdi_i, shreg[DW-1:1]} : {shreg[DW-2:0], sdi_i};
    rx_word  = ord ? (shreg_sh >> pad_q)
                   : (shreg_sh & ({DW{1'b1}} >> pad_q));
  end

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: a load starts a transfer, the last strobe ends it.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (ld_i) state_nxt = SHIFT;
      SHIFT:   if (sh_en_i && (cnt == ONE_L)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State-decoded controls and the serial output bit.
  // ld_i is only honoured in IDLE, and sh_en_i only in SHIFT. A load that
  // coincides with a strobe therefore never shifts.
  always_comb begin
    load   = (state == IDLE) && ld_i;
    shift  = (state == SHIFT) && sh_en_i;
    last   = shift && (cnt == ONE_L);
    busy_o = (state == SHIFT);
    sdo_o  = 1'b0;
    if (state == SHIFT) begin
      sdo_o = ord ? shreg[0] : shreg[DW-1];
    end
  end

  // Datapath registers: shift register, bit counter, latched length/order,
  // completion pulse and received word.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      shreg  <= '0;
      cnt    <= '0;
      len_q  <= '0;
      ord    <= 1'b0;
      done_o <= 1'b0;
      data_o <= '0;
    end else begin
      done_o <= last;
      if (load) begin
        shreg <= shreg_ld;
        cnt   <= len_eff;
        len_q <= len_eff;
        ord   <= lsb_first_i;
      end else if (shift) begin
        shreg <= shreg_sh;
        cnt   <= cnt - ONE_L;
      end
      if (last) begin
        data_o <= rx_word;
      end
    end
  end

endmodule
